// File: rtl/memory_pipelined.sv
// memory_pipelined: cacheline store with a read-request queue feeding a
// fixed-latency, stallable response pipeline. Writes are always accepted and
// commit on their own edge; reads sample storage when they issue (write-first).
// Optional feature: define MEMORY_PIPELINED_STATS_EN to add the stat_reads,
// stat_writes and stat_stall counter outputs.

package memory_pipelined_pkg;
    localparam int unsigned TAG_W  = 20;
    localparam int unsigned IDX_W  = 8;
    localparam int unsigned OFF_W  = 4;
    localparam int unsigned LINE_W = 128;

    typedef logic [LINE_W-1:0] cacheline_t;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [IDX_W-1:0] idx;
        logic [OFF_W-1:0] offset;
    } pptr_t;
endpackage

module memory_pipelined
    import memory_pipelined_pkg::*;
#(
    parameter int unsigned LATENCY    = 4,
    parameter int unsigned QDEPTH     = 4,
    parameter int unsigned DEPTH_BITS = 14
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_ren,
    input  pptr_t      req_raddr,
    output logic       req_rready,
    input  logic       req_wen,
    input  pptr_t      req_waddr,
    input  cacheline_t req_wcacheline,
    output logic       rec_en,
    input  logic       rec_ready,
    output pptr_t      rec_addr,
    output cacheline_t rec_cacheline
`ifdef MEMORY_PIPELINED_STATS_EN
    ,
    output logic [31:0] stat_reads,
    output logic [31:0] stat_writes,
    output logic [31:0] stat_stall
`endif
);

    localparam int unsigned QPTR_W = $clog2(QDEPTH);
    localparam int unsigned QCNT_W = $clog2(QDEPTH + 1);
    localparam int unsigned LINES  = 2 ** DEPTH_BITS;

    typedef logic [DEPTH_BITS-1:0] line_t;

    // Storage line index: {tag, idx} truncated to the implemented depth.
    function automatic line_t line_of(input pptr_t a);
        return line_t'({a.tag, a.idx});
    endfunction

    // Storage and queue payload (no reset)
    cacheline_t mem [LINES];
    pptr_t      q_mem [QDEPTH];

    // Queue bookkeeping
    logic [QPTR_W-1:0] q_rd_ptr;
    logic [QPTR_W-1:0] q_wr_ptr;
    logic [QCNT_W-1:0] q_count;
    logic              q_empty;

    // Response pipeline; index LATENCY-1 is the output stage
    logic [LATENCY-1:0] st_valid;
    pptr_t              st_addr [LATENCY];
    cacheline_t         st_data [LATENCY];

    // Handshake and issue control
    logic       stall;
    logic       accept;
    logic       enq;
    logic       deq;
    logic       issue_valid;
    pptr_t      issue_addr;
    line_t      issue_line;
    cacheline_t issue_data;

    // Offset bits (and tag bits above the depth) never select storage.
    logic unused_waddr_bits;
    assign unused_waddr_bits = ^req_waddr;

    assign q_empty    = (q_count == '0);
    assign req_rready = (q_count != QCNT_W'(QDEPTH));
    assign accept     = req_ren && req_rready;
    assign stall      = rec_en && !rec_ready;

    assign rec_en        = st_valid[LATENCY-1];
    assign rec_addr      = st_addr[LATENCY-1];
    assign rec_cacheline = st_data[LATENCY-1];

    // Choose what issues this edge: queue head first, else fall-through of the incoming read.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (which would infer a latch).
        issue_valid = 1'b0;
        issue_addr  = q_mem[q_rd_ptr];
        enq         = 1'b0;
        deq         = 1'b0;
        if (!stall) begin
            if (!q_empty) begin
                issue_valid = 1'b1;
                deq         = 1'b1;
                enq         = accept;
            end else if (accept) begin
                issue_valid = 1'b1;
                issue_addr  = req_raddr;
            end
        end else begin
            enq = accept;
        end
        issue_line = line_of(issue_addr);
        if (req_wen && (line_of(req_waddr) == issue_line)) begin
            issue_data = req_wcacheline;
        end else begin
            issue_data = mem[issue_line];
        end
    end

    // Storage write port and queue payload write.
    always_ff @(posedge clk) begin
        // NOTE: large data arrays are not reset; only the control state that says which entries are live is.
        if (req_wen) begin
            mem[line_of(req_waddr)] <= req_wcacheline;
        end
        if (enq) begin
            q_mem[q_wr_ptr] <= req_raddr;
        end
    end

    // Queue pointers and occupancy; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            q_rd_ptr <= '0;
            q_wr_ptr <= '0;
            q_count  <= '0;
        end else begin
            if (enq) begin
                q_wr_ptr <= q_wr_ptr + QPTR_W'(1);
            end
            if (deq) begin
                q_rd_ptr <= q_rd_ptr + QPTR_W'(1);
            end
            case ({enq, deq})
                2'b10:   q_count <= q_count + QCNT_W'(1);
                2'b01:   q_count <= q_count - QCNT_W'(1);
                default: q_count <= q_count;
            endcase
        end
    end

    // Response pipeline: advances as a whole, freezes while the output is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_valid <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                st_addr[i] <= '0;
                st_data[i] <= '0;
            end
        end else if (!stall) begin
            for (int i = LATENCY - 1; i > 0; i--) begin
                st_valid[i] <= st_valid[i-1];
                st_addr[i]  <= st_addr[i-1];
                st_data[i]  <= st_data[i-1];
            end
            st_valid[0] <= issue_valid;
            st_addr[0]  <= issue_valid ? issue_addr : '0;
            st_data[0]  <= issue_valid ? issue_data : '0;
        end
    end

`ifdef MEMORY_PIPELINED_STATS_EN
    // Activity counters; wrap at 2**32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_reads  <= '0;
            stat_writes <= '0;
            stat_stall  <= '0;
        end else begin
            if (rec_en && rec_ready) begin
                stat_reads <= stat_reads + 32'd1;
            end
            if (req_wen) begin
                stat_writes <= stat_writes + 32'd1;
            end
            if (stall) begin
                stat_stall <= stat_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_memory_pipelined.sv
// tb_memory_pipelined: directed scenarios plus a randomized run checked
// against a queue-and-array reference model. Two instances: default
// parameters (LATENCY=4, QDEPTH=4) and a LATENCY=1 copy.

module tb_memory_pipelined;
    import memory_pipelined_pkg::*;

    localparam int LAT = 4;
    localparam int QD  = 4;
    localparam int DB  = 14;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Main instance signals
    logic       ren, rready, wen, rec_en, rec_ready;
    pptr_t      raddr, waddr, rec_addr;
    cacheline_t wdata, rec_data;

    // LATENCY=1 instance signals
    logic       l1_ren, l1_rready, l1_wen, l1_rec_en, l1_rec_ready;
    pptr_t      l1_raddr, l1_waddr, l1_rec_addr;
    cacheline_t l1_wdata, l1_rec_data;

`ifdef MEMORY_PIPELINED_STATS_EN
    logic [31:0] stat_reads, stat_writes, stat_stall;
    logic [31:0] l1_stat_reads, l1_stat_writes, l1_stat_stall;
`endif

    memory_pipelined #(.LATENCY(LAT), .QDEPTH(QD), .DEPTH_BITS(DB)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_ren(ren), .req_raddr(raddr), .req_rready(rready),
        .req_wen(wen), .req_waddr(waddr), .req_wcacheline(wdata),
        .rec_en(rec_en), .rec_ready(rec_ready), .rec_addr(rec_addr), .rec_cacheline(rec_data)
`ifdef MEMORY_PIPELINED_STATS_EN
        , .stat_reads(stat_reads), .stat_writes(stat_writes), .stat_stall(stat_stall)
`endif
    );

    memory_pipelined #(.LATENCY(1), .QDEPTH(QD), .DEPTH_BITS(DB)) u_dut_l1 (
        .clk(clk), .rst_n(rst_n),
        .req_ren(l1_ren), .req_raddr(l1_raddr), .req_rready(l1_rready),
        .req_wen(l1_wen), .req_waddr(l1_waddr), .req_wcacheline(l1_wdata),
        .rec_en(l1_rec_en), .rec_ready(l1_rec_ready), .rec_addr(l1_rec_addr), .rec_cacheline(l1_rec_data)
`ifdef MEMORY_PIPELINED_STATS_EN
        , .stat_reads(l1_stat_reads), .stat_writes(l1_stat_writes), .stat_stall(l1_stat_stall)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        pptr_t      addr;
        cacheline_t data;
    } exp_t;

    exp_t       exp_q[$];
    cacheline_t model_mem [32];

    // Advance one clock; inputs are driven and outputs observed 1 time unit after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic pptr_t mk(input int unsigned line, input int unsigned off);
        pptr_t       a;
        logic [27:0] l;
        logic [3:0]  o;
        l = line[27:0];
        o = off[3:0];
        a.tag    = l[27:8];
        a.idx    = l[7:0];
        a.offset = o;
        return a;
    endfunction

    function automatic cacheline_t rnd_line();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic bit line_pending(input int unsigned line);
        foreach (exp_q[i]) begin
            if ({exp_q[i].addr.tag, exp_q[i].addr.idx} == line[27:0]) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic idle();
        ren = 1'b0; raddr = '0; wen = 1'b0; waddr = '0; wdata = '0; rec_ready = 1'b1;
        l1_ren = 1'b0; l1_raddr = '0; l1_wen = 1'b0; l1_waddr = '0; l1_wdata = '0; l1_rec_ready = 1'b1;
    endtask

    task automatic write_line(input pptr_t a, input cacheline_t d);
        wen = 1'b1; waddr = a; wdata = d;
        cyc();
        wen = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        repeat (3) cyc();
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (rec_en !== 1'b0) begin n_bad++; $display("FAIL reset_rec_en: got %b want 0", rec_en); end
        n_cmp++; if (rec_addr !== '0) begin n_bad++; $display("FAIL reset_rec_addr: got %h want 0", rec_addr); end
        n_cmp++; if (rec_data !== '0) begin n_bad++; $display("FAIL reset_rec_cacheline: got %h want 0", rec_data); end
        n_cmp++; if (rready !== 1'b1) begin n_bad++; $display("FAIL reset_rready: got %b want 1", rready); end
        n_cmp++; if (l1_rec_en !== 1'b0) begin n_bad++; $display("FAIL reset_l1_rec_en: got %b want 0", l1_rec_en); end
    endtask

    task automatic test_latency1();
        cacheline_t a_data;
        a_data = rnd_line();
        l1_wen = 1'b1; l1_waddr = mk(5, 0); l1_wdata = a_data;
        cyc();
        l1_wen = 1'b0;
        l1_ren = 1'b1; l1_raddr = mk(5, 0); l1_rec_ready = 1'b1;
        n_cmp++; if (l1_rec_en !== 1'b0) begin n_bad++; $display("FAIL l1_early: rec_en got %b want 0", l1_rec_en); end
        cyc();
        l1_ren = 1'b0;
        n_cmp++; if (l1_rec_en !== 1'b1) begin n_bad++; $display("FAIL l1_rec_en: got %b want 1", l1_rec_en); end
        n_cmp++; if (l1_rec_data !== a_data) begin n_bad++; $display("FAIL l1_data: got %h want %h", l1_rec_data, a_data); end
        n_cmp++; if (l1_rec_addr !== mk(5, 0)) begin n_bad++; $display("FAIL l1_addr: got %h want %h", l1_rec_addr, mk(5, 0)); end
        cyc();
        n_cmp++; if (l1_rec_en !== 1'b0) begin n_bad++; $display("FAIL l1_dup: rec_en got %b want 0", l1_rec_en); end
    endtask

    task automatic test_back_to_back();
        cacheline_t d [3];
        for (int i = 0; i < 3; i++) begin
            d[i] = rnd_line();
            write_line(mk(i + 1, 0), d[i]);
        end
        rec_ready = 1'b1;
        for (int t = 0; t < 10; t++) begin
            ren = (t < 3);
            raddr = (t < 3) ? mk(t + 1, 0) : '0;
            n_cmp++;
            if (rec_en !== (t >= LAT && t <= LAT + 2)) begin
                n_bad++; $display("FAIL b2b_rec_en t=%0d: got %b want %b", t, rec_en, (t >= LAT && t <= LAT + 2));
            end
            if (t >= LAT && t <= LAT + 2) begin
                n_cmp++;
                if (rec_addr !== mk(t - LAT + 1, 0) || rec_data !== d[t - LAT]) begin
                    n_bad++; $display("FAIL b2b_resp t=%0d: got %h/%h want %h/%h", t, rec_addr, rec_data, mk(t - LAT + 1, 0), d[t - LAT]);
                end
            end
            cyc();
        end
        ren = 1'b0;
    endtask

    task automatic test_fill_drain();
        cacheline_t d [8];
        int accepted, drop_t, got;
        for (int i = 0; i < 8; i++) begin
            d[i] = rnd_line();
            write_line(mk(16 + i, 0), d[i]);
        end
        rec_ready = 1'b0;
        accepted = 0;
        drop_t = -1;
        for (int t = 0; t < 40; t++) begin
            if (!rready && drop_t < 0) drop_t = t;
            if (drop_t >= 0 && t >= drop_t + 3) break;
            ren = 1'b1;
            raddr = (drop_t < 0) ? mk(16 + accepted, 0) : mk(31, 0);
            if (rready) accepted++;
            cyc();
        end
        ren = 1'b0;
        n_cmp++; if (drop_t != LAT + QD) begin n_bad++; $display("FAIL fill_drop_cycle: got %0d want %0d", drop_t, LAT + QD); end
        n_cmp++; if (accepted != LAT + QD) begin n_bad++; $display("FAIL fill_accepted: got %0d want %0d", accepted, LAT + QD); end
        n_cmp++; if (rec_en !== 1'b1 || rec_addr !== mk(16, 0)) begin n_bad++; $display("FAIL fill_hold: got %b/%h want 1/%h", rec_en, rec_addr, mk(16, 0)); end
        rec_ready = 1'b1;
        n_cmp++; if (rready !== 1'b0) begin n_bad++; $display("FAIL full_dequeue_rready: got %b want 0", rready); end
        got = 0;
        for (int t = 0; t < 30; t++) begin
            if (rec_en) begin
                n_cmp++;
                if (got >= 8) begin
                    n_bad++; $display("FAIL drain_extra: got %h want none", rec_addr);
                end else if (rec_addr !== mk(16 + got, 0) || rec_data !== d[got]) begin
                    n_bad++; $display("FAIL drain_order #%0d: got %h/%h want %h/%h", got, rec_addr, rec_data, mk(16 + got, 0), d[got]);
                end
                got++;
            end
            cyc();
        end
        n_cmp++; if (got != 8) begin n_bad++; $display("FAIL drain_count: got %0d want 8", got); end
        n_cmp++; if (rready !== 1'b1) begin n_bad++; $display("FAIL drain_rready: got %b want 1", rready); end
    endtask

    task automatic test_write_first();
        cacheline_t old_d, b_data, x_data, y_data;
        int got;
        old_d = rnd_line(); b_data = rnd_line();
        write_line(mk(7, 0), old_d);
        rec_ready = 1'b1;
        ren = 1'b1; raddr = mk(7, 0);
        wen = 1'b1; waddr = mk(7, 0); wdata = b_data;
        cyc();
        ren = 1'b0; wen = 1'b0;
        got = 0;
        for (int t = 0; t < 12 && got == 0; t++) begin
            if (rec_en) begin
                got = 1;
                n_cmp++; if (rec_data !== b_data) begin n_bad++; $display("FAIL write_first: got %h want %h", rec_data, b_data); end
            end
            cyc();
        end
        n_cmp++; if (got == 0) begin n_bad++; $display("FAIL write_first_timeout: got no response want 1"); end
        // A queued read sees a write committed while it waits.
        x_data = rnd_line(); y_data = rnd_line();
        write_line(mk(8, 0), x_data);
        write_line(mk(32, 0), rnd_line());
        rec_ready = 1'b0;
        ren = 1'b1; raddr = mk(32, 0);
        cyc();
        ren = 1'b0;
        for (int t = 0; t < 12 && !rec_en; t++) cyc();
        ren = 1'b1; raddr = mk(8, 0);
        cyc();
        ren = 1'b0;
        write_line(mk(8, 0), y_data);
        rec_ready = 1'b1;
        got = 0;
        for (int t = 0; t < 20; t++) begin
            if (rec_en) begin
                if (rec_addr === mk(8, 0)) begin
                    got = 1;
                    n_cmp++; if (rec_data !== y_data) begin n_bad++; $display("FAIL queued_sees_write: got %h want %h", rec_data, y_data); end
                end
            end
            cyc();
        end
        n_cmp++; if (got == 0) begin n_bad++; $display("FAIL queued_sees_write_timeout: got no response want 1"); end
    endtask

    task automatic test_alias();
        cacheline_t c_data;
        int got;
        c_data = rnd_line();
        write_line(mk(32'h4009, 3), c_data);
        rec_ready = 1'b1;
        ren = 1'b1; raddr = mk(9, 0);
        cyc();
        ren = 1'b0;
        got = 0;
        for (int t = 0; t < 12 && got == 0; t++) begin
            if (rec_en) begin
                got = 1;
                n_cmp++;
                if (rec_data !== c_data || rec_addr !== mk(9, 0)) begin
                    n_bad++; $display("FAIL alias_trunc: got %h/%h want %h/%h", rec_addr, rec_data, mk(9, 0), c_data);
                end
            end
            cyc();
        end
        n_cmp++; if (got == 0) begin n_bad++; $display("FAIL alias_timeout: got no response want 1"); end
    endtask

    task automatic test_reset_mid();
        cacheline_t p_data;
        int stale, got;
        p_data = rnd_line();
        write_line(mk(48, 0), p_data);
        rec_ready = 1'b0;
        for (int t = 0; t < LAT + 3; t++) begin
            ren = 1'b1; raddr = mk(1, 0);
            cyc();
        end
        ren = 1'b0;
        n_cmp++; if (rec_en !== 1'b1) begin n_bad++; $display("FAIL mid_prestall: got %b want 1", rec_en); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (rec_en !== 1'b0) begin n_bad++; $display("FAIL mid_async_rec_en: got %b want 0", rec_en); end
        n_cmp++; if (rec_addr !== '0 || rec_data !== '0) begin n_bad++; $display("FAIL mid_async_rec_bus: got %h/%h want 0/0", rec_addr, rec_data); end
        cyc();
        rst_n = 1'b1;
        rec_ready = 1'b1;
        stale = 0;
        for (int t = 0; t < 12; t++) begin
            cyc();
            if (rec_en) stale++;
        end
        n_cmp++; if (stale != 0) begin n_bad++; $display("FAIL mid_stale: got %0d responses want 0", stale); end
        n_cmp++; if (rready !== 1'b1) begin n_bad++; $display("FAIL mid_rready: got %b want 1", rready); end
        ren = 1'b1; raddr = mk(48, 0);
        cyc();
        ren = 1'b0;
        got = 0;
        for (int t = 0; t < 12 && got == 0; t++) begin
            if (rec_en) begin
                got = 1;
                n_cmp++; if (rec_data !== p_data) begin n_bad++; $display("FAIL storage_kept: got %h want %h", rec_data, p_data); end
            end
            cyc();
        end
        n_cmp++; if (got == 0) begin n_bad++; $display("FAIL storage_kept_timeout: got no response want 1"); end
    endtask

    task automatic test_random();
        bit         prev_stall;
        pptr_t      prev_addr;
        cacheline_t prev_data;
        exp_t       e;
        int unsigned wl;
        exp_q.delete();
        for (int i = 0; i < 32; i++) begin
            model_mem[i] = rnd_line();
            write_line(mk(i, $urandom_range(0, 15)), model_mem[i]);
        end
        prev_stall = 1'b0; prev_addr = '0; prev_data = '0;
        for (int t = 0; t < 400; t++) begin
            if (prev_stall) begin
                n_cmp++;
                if (rec_en !== 1'b1 || rec_addr !== prev_addr || rec_data !== prev_data) begin
                    n_bad++; $display("FAIL rnd_stall_hold t=%0d: got %b/%h want 1/%h", t, rec_en, rec_addr, prev_addr);
                end
            end
            if (exp_q.size() < QD) begin
                n_cmp++; if (rready !== 1'b1) begin n_bad++; $display("FAIL rnd_rready t=%0d: got %b want 1 (outstanding %0d)", t, rready, exp_q.size()); end
            end
            rec_ready = ($urandom_range(0, 3) != 0);
            if (rec_en && rec_ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++; $display("FAIL rnd_spurious t=%0d: got %h want none", t, rec_addr);
                end else begin
                    e = exp_q.pop_front();
                    if (rec_addr !== e.addr || rec_data !== e.data) begin
                        n_bad++; $display("FAIL rnd_resp t=%0d: got %h/%h want %h/%h", t, rec_addr, rec_data, e.addr, e.data);
                    end
                end
            end
            ren = $urandom_range(0, 1);
            raddr = mk($urandom_range(0, 31), $urandom_range(0, 15));
            wl = $urandom_range(0, 31);
            wen = ($urandom_range(0, 2) == 0) && !line_pending(wl);
            waddr = mk(wl, $urandom_range(0, 15));
            wdata = rnd_line();
            if (wen) model_mem[wl] = wdata;
            if (ren && rready) begin
                e.addr = raddr;
                e.data = model_mem[raddr.idx[4:0]];
                exp_q.push_back(e);
            end
            prev_stall = rec_en && !rec_ready;
            prev_addr = rec_addr;
            prev_data = rec_data;
            cyc();
        end
        ren = 1'b0; wen = 1'b0; rec_ready = 1'b1;
        for (int t = 0; t < 200; t++) begin
            if (rec_en) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++; $display("FAIL rnd_drain_spurious: got %h want none", rec_addr);
                end else begin
                    e = exp_q.pop_front();
                    if (rec_addr !== e.addr || rec_data !== e.data) begin
                        n_bad++; $display("FAIL rnd_drain_resp: got %h/%h want %h/%h", rec_addr, rec_data, e.addr, e.data);
                    end
                end
            end
            cyc();
        end
        n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL rnd_drain_timeout: got %0d outstanding want 0", exp_q.size()); end
    endtask

`ifdef MEMORY_PIPELINED_STATS_EN
    task automatic test_stats();
        do_reset();
        n_cmp++; if (stat_reads !== 0 || stat_writes !== 0 || stat_stall !== 0) begin
            n_bad++; $display("FAIL stats_reset: got %0d/%0d/%0d want 0/0/0", stat_reads, stat_writes, stat_stall);
        end
        write_line(mk(60, 0), rnd_line());
        write_line(mk(61, 0), rnd_line());
        for (int t = 0; t < 30; t++) begin
            ren = (t < 5);
            raddr = mk(60, 0);
            rec_ready = (t >= LAT + 3);
            cyc();
        end
        ren = 1'b0;
        n_cmp++; if (stat_reads !== 32'd5) begin n_bad++; $display("FAIL stat_reads: got %0d want 5", stat_reads); end
        n_cmp++; if (stat_writes !== 32'd2) begin n_bad++; $display("FAIL stat_writes: got %0d want 2", stat_writes); end
        n_cmp++; if (stat_stall !== 32'd3) begin n_bad++; $display("FAIL stat_stall: got %0d want 3", stat_stall); end
    endtask
`endif

    initial begin
        idle();
        test_reset();
        test_latency1();
        test_back_to_back();
        test_fill_drain();
        test_write_first();
        test_alias();
        test_reset_mid();
        test_random();
`ifdef MEMORY_PIPELINED_STATS_EN
        test_stats();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/memory_pipelined.md
MEMORY_PIPELINED -- requirements
Module: memory_pipelined

Interface
REQ-001 SHALL have parameter LATENCY, default 4: response pipeline stages, legal 1..16.
REQ-002 SHALL have parameter QDEPTH, default 4: read request queue entries, power of two, legal 2..32.
REQ-003 SHALL have parameter DEPTH_BITS, default 14: line-index width; storage holds 2**DEPTH_BITS cachelines.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port req_ren  input  1  read request valid.
REQ-007 SHALL have port req_raddr  input  pptr_t  read address.
REQ-008 SHALL have port req_rready  output  1  read queue can accept; equals not-full, driven from registered state only.
REQ-009 SHALL have port req_wen  input  1  write strobe; always accepted.
REQ-010 SHALL have port req_waddr  input  pptr_t  write address.
REQ-011 SHALL have port req_wcacheline  input  cacheline_t  write data.
REQ-012 SHALL have port rec_en  output  1  response valid.
REQ-013 SHALL have port rec_ready  input  1  response accepted by consumer.
REQ-014 SHALL have port rec_addr  output  pptr_t  address of returned line.
REQ-015 SHALL have port rec_cacheline  output  cacheline_t  returned line.

Function
REQ-016 SHALL index storage with {tag, idx} of the address, truncated to its low DEPTH_BITS bits.
REQ-017 SHALL accept a read on an edge where req_ren and req_rready are both 1; reads offered with req_rready=0 are ignored.
REQ-018 SHALL issue the oldest accepted read, one per cycle, into stage 1 of the pipeline when the pipeline is not stalled; when the queue is empty and not stalled, the incoming read issues on its accept edge (fall-through).
REQ-019 SHALL sample storage at issue; a write to the same line on the issue edge SHALL be returned (write-first).
REQ-020 SHALL advance all stages one per cycle; the issued read appears with rec_en=1 after LATENCY edges from issue (LATENCY=1, empty queue: rec_en high the cycle after req_ren).
REQ-021 SHALL stall the whole pipeline and hold rec_en/rec_addr/rec_cacheline stable while rec_en=1 and rec_ready=0; no issue occurs during a stall; accepts continue until full.
REQ-022 SHALL complete a response on an edge with rec_en=1 and rec_ready=1; responses return in accept order, none dropped or duplicated.
REQ-023 SHALL, when full, deassert req_rready even if a dequeue occurs the same edge.
REQ-024 SHALL apply writes on the edge req_wen=1 regardless of stall or queue state; queued reads see writes committed up to and including their issue edge.
REQ-025 SHALL wrap queue pointers modulo QDEPTH with an explicit occupancy count of 0..QDEPTH.

Reset
REQ-026 SHALL on rst_n=0 immediately clear queue, pipeline valids, rec_en, rec_addr and rec_cacheline to 0, and drive req_rready=1 after release.
REQ-027 SHALL discard in-flight and queued reads on reset mid-operation; storage contents SHALL NOT be reset.

Configuration
REQ-028 SHALL, with MEMORY_PIPELINED_STATS_EN defined, add outputs stat_reads (32 bit, completed responses), stat_writes (32 bit, writes applied) and stat_stall (32 bit, stalled cycles), reset to 0, wrapping at 2**32.
REQ-029 SHALL, without MEMORY_PIPELINED_STATS_EN, omit those ports and counters entirely.

Verification
REQ-030 SHALL cover: LATENCY=1, write line 0x5 data A, next cycle read 0x5, rec_ready=1 -> rec_en high one cycle later, rec_cacheline=A.
REQ-031 SHALL cover: LATENCY=4, reads to 0x1,0x2,0x3 back-to-back -> responses on edges 4,5,6 after first accept, in order.
REQ-032 SHALL cover: QDEPTH=4, rec_ready=0 with continuous reads -> req_rready falls after pipeline plus 4 queue entries fill; rec_ready=1 drains all, in order.
REQ-033 SHALL cover: read 0x7 and write 0x7 data B on the same issue edge -> response returns B.
REQ-034 SHALL cover: rst_n pulsed low with 3 reads queued -> rec_en=0 at once, no stale responses after release, req_rready=1.
REQ-035 SHALL cover: with MEMORY_PIPELINED_STATS_EN, 5 reads, 2 writes, 3 stalled cycles -> stat_reads=5, stat_writes=2, stat_stall=3.
